// File: rtl/rv_exec_sequencer.sv
// Multi-cycle RV32I integer execute sequencer.
// Each instruction goes through four states: IDLE -> READ -> EXEC -> WB.
//   IDLE: accept and latch one instruction word.
//   READ: strobe the register file read port.
//   EXEC: take the registered read data and compute the ALU result.
//   WB:   retire the instruction, writing back when the destination allows it.
// Handshake: a word transfers on a rising clk edge where instr_valid_i && instr_ready_o.
// instr_ready_o is high only in IDLE, and is held low while rst is asserted.
// The write commits on the WB->IDLE edge, before the next READ, so no RAW hazard exists.
module rv_exec_sequencer #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid_i,
  output logic            instr_ready_o,
  input  logic [31:0]     instr_i,
  output logic [RA_W-1:0] rs1_addr_o,
  output logic [RA_W-1:0] rs2_addr_o,
  output logic            read_en_o,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  output logic            write_en_o,
  output logic [RA_W-1:0] write_addr_o,
  output logic [XLEN-1:0] write_data_o,
  output logic            done_o,
  output logic            illegal_o,
  output logic [1:0]      state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_e;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] F7_Z  = 7'b0000000;
  localparam logic [6:0] F7_AS = 7'b0100000;

  state_e          state_q, state_d;
  logic [31:0]     ir_q, ir_d;
  logic            illegal_q, illegal_d;
  logic            wr_q, wr_d;
  logic [RA_W-1:0] write_addr_q, write_addr_d;
  logic [XLEN-1:0] write_data_q, write_data_d;

  // Instruction fields
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [RA_W-1:0] rd;

  assign opcode = ir_q[6:0];
  assign funct3 = ir_q[14:12];
  assign funct7 = ir_q[31:25];
  assign rd     = ir_q[7 +: RA_W];

  // ALU operands and candidate results
  logic [XLEN-1:0] op_a, op_b, imm_sext;
  logic [4:0]      shamt;
  logic [XLEN-1:0] add_res, sub_res, sll_res, srl_res, sra_res, slt_res, sltu_res;
  logic [XLEN-1:0] alu_result;
  logic            alu_legal;

  assign imm_sext = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
  assign op_a     = rs1_data_i;
  assign op_b     = (opcode == OP_R) ? rs2_data_i : imm_sext;
  assign shamt    = op_b[4:0];
  assign add_res  = op_a + op_b;
  assign sub_res  = op_a - op_b;
  assign sll_res  = op_a << shamt;
  assign srl_res  = op_a >> shamt;
  assign sra_res  = $unsigned($signed(op_a) >>> shamt);
  assign slt_res  = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
  assign sltu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};

  // Decode the latched word and select the ALU result; unsupported encodings stay illegal
  always_comb begin
    alu_result = '0;
    alu_legal  = 1'b0;
    if (opcode == OP_R) begin
      if (funct7 == F7_Z) begin
        alu_legal = 1'b1;
        case (funct3)
          3'b000:  alu_result = add_res;
          3'b001:  alu_result = sll_res;
          3'b010:  alu_result = slt_res;
          3'b011:  alu_result = sltu_res;
          3'b100:  alu_result = op_a ^ op_b;
          3'b101:  alu_result = srl_res;
          3'b110:  alu_result = op_a | op_b;
          default: alu_result = op_a & op_b;
        endcase
      end else if (funct7 == F7_AS) begin
        if (funct3 == 3'b000) begin
          alu_legal  = 1'b1;
          alu_result = sub_res;
        end else if (funct3 == 3'b101) begin
          alu_legal  = 1'b1;
          alu_result = sra_res;
        end
      end
    end else if (opcode == OP_I) begin
      case (funct3)
        3'b000: begin alu_legal = 1'b1; alu_result = add_res;     end
        3'b010: begin alu_legal = 1'b1; alu_result = slt_res;     end
        3'b011: begin alu_legal = 1'b1; alu_result = sltu_res;    end
        3'b100: begin alu_legal = 1'b1; alu_result = op_a ^ op_b; end
        3'b110: begin alu_legal = 1'b1; alu_result = op_a | op_b; end
        3'b111: begin alu_legal = 1'b1; alu_result = op_a & op_b; end
        3'b001: begin
          if (funct7 == F7_Z) begin
            alu_legal  = 1'b1;
            alu_result = sll_res;
          end
        end
        default: begin
          if (funct7 == F7_Z) begin
            alu_legal  = 1'b1;
            alu_result = srl_res;
          end else if (funct7 == F7_AS) begin
            alu_legal  = 1'b1;
            alu_result = sra_res;
          end
        end
      endcase
    end
  end

  // Next-state and datapath register update for the four-state sequencer
  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    illegal_d    = illegal_q;
    wr_d         = wr_q;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    case (state_q)
      IDLE: begin
        if (instr_valid_i) begin
          ir_d    = instr_i;
          state_d = READ;
        end
      end
      READ: state_d = EXEC;
      EXEC: begin
        illegal_d = ~alu_legal;
        wr_d      = alu_legal && (rd != '0);
        // write_addr/write_data only move when a real write is about to happen
        if (alu_legal && (rd != '0)) begin
          write_addr_d = rd;
          write_data_d = alu_result;
        end
        state_d = WB;
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ir_q         <= '0;
      illegal_q    <= 1'b0;
      wr_q         <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
    end else begin
      state_q      <= state_d;
      ir_q         <= ir_d;
      illegal_q    <= illegal_d;
      wr_q         <= wr_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
    end
  end

  assign instr_ready_o = (state_q == IDLE) && !rst;
  assign read_en_o     = (state_q == READ);
  assign rs1_addr_o    = ir_q[15 +: RA_W];
  assign rs2_addr_o    = ir_q[20 +: RA_W];
  assign done_o        = (state_q == WB);
  assign write_en_o    = (state_q == WB) && wr_q;
  assign illegal_o     = (state_q == WB) && illegal_q;
  assign write_addr_o  = write_addr_q;
  assign write_data_o  = write_data_q;
  assign state_o       = state_q;

endmodule
